// File: rtl/lives_pkg.sv
// Shared types and constants for the lives tracker and the lives display.
// Optional build macro used by lives_tracker: LIVES_EDGE_DETECT_EN.
package lives_pkg;

  localparam int LIVES_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    GRACE = 2'd2,
    OVER  = 2'd3
  } lives_state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;

  // Maps a lives count to the digit pattern the display shows.
  function automatic logic [6:0] lives_to_seg(input logic [LIVES_W-1:0] i_lives);
    logic [6:0] seg;
    case (i_lives)
      2'd0:    seg = SEG_0;
      2'd1:    seg = SEG_1;
      2'd2:    seg = SEG_2;
      default: seg = SEG_3;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: a held level produces one pulse, one
// cycle after the rise. Both registers reset to 0.
module edge_pulse (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  // Remember the previous level and register the rise as a one-cycle pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_pulse <= i_d & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/lives_tracker.sv
// Lives tracker: keeps the remaining lives count for the HUD, runs the
// post-miss invulnerability window and flags game over.
// Optional build macro: LIVES_EDGE_DETECT_EN (edge-detect event inputs,
// latency becomes 2 cycles; otherwise inputs are level-sampled, latency 1).
// Event inputs are sampled on every rising clk edge; there is no handshake.
import lives_pkg::*;

module lives_tracker #(
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 3,
  parameter int GRACE_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               miss,
  input  logic               bomb,
  input  logic               bonus,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               invuln,
  output logic               game_over,
  output logic               life_lost,
  output lives_state_t       dbg_state
);

  localparam int CNT_W = $clog2(GRACE_CYCLES + 1);
  localparam logic [LIVES_W-1:0] START_L    = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);

  logic w_start;
  logic w_miss;
  logic w_bomb;
  logic w_bonus;

`ifdef LIVES_EDGE_DETECT_EN
  edge_pulse u_ep_start (.clk(clk), .resetn(resetn), .i_d(start), .o_pulse(w_start));
  edge_pulse u_ep_miss  (.clk(clk), .resetn(resetn), .i_d(miss),  .o_pulse(w_miss));
  edge_pulse u_ep_bomb  (.clk(clk), .resetn(resetn), .i_d(bomb),  .o_pulse(w_bomb));
  edge_pulse u_ep_bonus (.clk(clk), .resetn(resetn), .i_d(bonus), .o_pulse(w_bonus));
`else
  assign w_start = start;
  assign w_miss  = miss;
  assign w_bomb  = bomb;
  assign w_bonus = bonus;
`endif

  lives_state_t       r_state;
  lives_state_t       w_state_nxt;
  logic [LIVES_W-1:0] r_lives;
  logic [LIVES_W-1:0] w_lives_nxt;
  logic [CNT_W-1:0]   r_grace_cnt;
  logic [CNT_W-1:0]   w_grace_cnt_nxt;
  logic               r_life_lost;
  logic               w_life_lost_nxt;

  // State, lives, grace counter and loss pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_lives     <= START_L;
      r_grace_cnt <= '0;
      r_life_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lives     <= w_lives_nxt;
      r_grace_cnt <= w_grace_cnt_nxt;
      r_life_lost <= w_life_lost_nxt;
    end
  end

  // Next-state logic; in play, bomb beats miss beats bonus.
  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_grace_cnt_nxt = r_grace_cnt;
    w_life_lost_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = PLAY;
          w_lives_nxt = START_L;
        end
      end
      PLAY: begin
        if (w_bomb) begin
          w_state_nxt     = OVER;
          w_lives_nxt     = '0;
          w_life_lost_nxt = 1'b1;
        end else if (w_miss) begin
          w_life_lost_nxt = 1'b1;
          // lives <= 1 also covers a defensive 0 so the count never wraps.
          if (r_lives <= LIVES_W'(1)) begin
            w_state_nxt = OVER;
            w_lives_nxt = '0;
          end else begin
            w_state_nxt     = GRACE;
            w_lives_nxt     = r_lives - LIVES_W'(1);
            w_grace_cnt_nxt = GRACE_LOAD;
          end
        end else if (w_bonus && (r_lives < MAX_L)) begin
          w_lives_nxt = r_lives + LIVES_W'(1);
        end
      end
      GRACE: begin
        if (w_bomb) begin
          w_state_nxt     = OVER;
          w_lives_nxt     = '0;
          w_life_lost_nxt = 1'b1;
          w_grace_cnt_nxt = '0;
        end else begin
          if (w_bonus && (r_lives < MAX_L)) begin
            w_lives_nxt = r_lives + LIVES_W'(1);
          end
          if (r_grace_cnt == '0) begin
            w_state_nxt = PLAY;
          end else begin
            w_grace_cnt_nxt = r_grace_cnt - CNT_W'(1);
          end
        end
      end
      OVER: begin
        w_lives_nxt = '0;
        if (w_start) begin
          w_state_nxt = PLAY;
          w_lives_nxt = START_L;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode straight from the registered state.
  always_comb begin
    playing   = (r_state == PLAY) || (r_state == GRACE);
    invuln    = (r_state == GRACE);
    game_over = (r_state == OVER);
    lives     = r_lives;
    life_lost = r_life_lost;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_lives_tracker.sv
// Directed bench for lives_tracker with GRACE_CYCLES=4, START/MAX=3.
import lives_pkg::*;

module tb_lives_tracker;

  logic               clk;
  logic               resetn;
  logic               start;
  logic               miss;
  logic               bomb;
  logic               bonus;
  logic [LIVES_W-1:0] lives;
  logic               playing;
  logic               invuln;
  logic               game_over;
  logic               life_lost;
  lives_state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  lives_tracker #(
    .START_LIVES (3),
    .MAX_LIVES   (3),
    .GRACE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .miss     (miss),
    .bomb     (bomb),
    .bonus    (bonus),
    .lives    (lives),
    .playing  (playing),
    .invuln   (invuln),
    .game_over(game_over),
    .life_lost(life_lost),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    miss   = 1'b0;
    bomb   = 1'b0;
    bonus  = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  // One-cycle event pulse; on return outputs reflect the sampled event.
  task automatic pulse(input logic s, input logic m, input logic b, input logic bo);
    start = s;
    miss  = m;
    bomb  = b;
    bonus = bo;
    tick();
    start = 1'b0;
    miss  = 1'b0;
    bomb  = 1'b0;
    bonus = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_lives", 32'(lives), 3);
    check("rst_playing", 32'(playing), 0);
    check("rst_invuln", 32'(invuln), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_lost", 32'(life_lost), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

`ifdef LIVES_EDGE_DETECT_EN
    // Two-cycle latency through the edge detectors.
    pulse(1, 0, 0, 0);
    check("ed_start_lat1", 32'(playing), 0);
    tick();
    check("ed_start_lat2", 32'(playing), 1);
    pulse(0, 1, 0, 0);
    check("ed_miss1_lat1", 32'(lives), 3);
    tick();
    check("ed_miss1_lat2", 32'(lives), 2);
    repeat (6) tick();
    pulse(0, 1, 0, 0);
    tick();
    check("ed_miss2", 32'(lives), 1);
    repeat (6) tick();
    check("ed_play_again", 32'(dbg_state), 32'(PLAY));
    bonus = 1'b1;
    tick();
    check("ed_bonus_c1", 32'(lives), 1);
    tick();
    check("ed_bonus_c2", 32'(lives), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ed_bonus_held", 32'(lives), 2);
    end
    bonus = 1'b0;
`else
    // Start.
    pulse(1, 0, 0, 0);
    check("start_lives", 32'(lives), 3);
    check("start_playing", 32'(playing), 1);
    check("start_invuln", 32'(invuln), 0);
    check("start_over", 32'(game_over), 0);

    // Miss, masked second miss, grace length of 4 cycles.
    pulse(0, 1, 0, 0);
    check("miss_lives", 32'(lives), 2);
    check("miss_lost", 32'(life_lost), 1);
    check("miss_inv_c1", 32'(invuln), 1);
    tick();
    check("miss_lost_drop", 32'(life_lost), 0);
    check("miss_inv_c2", 32'(invuln), 1);
    pulse(0, 1, 0, 0);
    check("grace_mask_lives", 32'(lives), 2);
    check("grace_mask_lost", 32'(life_lost), 0);
    check("miss_inv_c3", 32'(invuln), 1);
    tick();
    check("miss_inv_c4", 32'(invuln), 1);
    tick();
    check("grace_end_inv", 32'(invuln), 0);
    check("grace_end_play", 32'(playing), 1);

    // Start in PLAY is ignored.
    pulse(1, 0, 0, 0);
    check("start_ignored", 32'(lives), 2);

    // Three spaced misses down to game over, then inert, then restart.
    do_reset();
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1, 0, 0);
      check("seq_miss_lives", 32'(lives), 32'(2 - i));
      check("seq_miss_lost", 32'(life_lost), 1);
      if (i < 2) repeat (5) tick();
    end
    check("seq_over", 32'(game_over), 1);
    check("seq_not_playing", 32'(playing), 0);
    pulse(0, 1, 0, 0);
    check("over_miss_lives", 32'(lives), 0);
    check("over_miss_lost", 32'(life_lost), 0);
    pulse(0, 0, 1, 1);
    check("over_bonus_lives", 32'(lives), 0);
    check("over_bomb_lost", 32'(life_lost), 0);
    pulse(1, 0, 0, 0);
    check("restart_lives", 32'(lives), 3);
    check("restart_playing", 32'(playing), 1);
    check("restart_lost", 32'(life_lost), 0);

    // Simultaneous events at lives=2: bomb wins.
    pulse(0, 1, 0, 0);
    repeat (4) tick();
    check("pri_in_play", 32'(dbg_state), 32'(PLAY));
    pulse(0, 1, 1, 1);
    check("pri_lives", 32'(lives), 0);
    check("pri_over", 32'(game_over), 1);
    check("pri_lost", 32'(life_lost), 1);

    // Bomb is not masked in GRACE.
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    check("gbomb_in_grace", 32'(invuln), 1);
    pulse(0, 0, 1, 0);
    check("gbomb_lives", 32'(lives), 0);
    check("gbomb_over", 32'(game_over), 1);
    check("gbomb_lost", 32'(life_lost), 1);

    // Held bonus saturates at 3; held miss costs only one life.
    pulse(1, 0, 0, 0);
    bonus = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bonus_sat", 32'(lives), 3);
    end
    bonus = 1'b0;
    miss = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_miss", 32'(lives), 2);
    end
    miss = 1'b0;
    repeat (4) tick();
    pulse(0, 1, 0, 0);
    check("to_one", 32'(lives), 1);
    repeat (4) tick();
    bonus = 1'b1;
    tick();
    check("held_bonus_c1", 32'(lives), 2);
    tick();
    check("held_bonus_c2", 32'(lives), 3);
    tick();
    check("held_bonus_c3", 32'(lives), 3);
    bonus = 1'b0;

    // Miss then bonus after grace; bonus accepted inside grace.
    pulse(0, 1, 0, 0);
    check("mb_miss", 32'(lives), 2);
    repeat (4) tick();
    pulse(0, 0, 0, 1);
    check("mb_bonus", 32'(lives), 3);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    check("grace_bonus_lives", 32'(lives), 3);
    check("grace_bonus_inv", 32'(invuln), 1);

    // Asynchronous reset mid-grace, checked before any clock edge.
    #2;
    resetn = 1'b0;
    #1;
    check("async_lives", 32'(lives), 3);
    check("async_state", 32'(dbg_state), 32'(IDLE));
    check("async_invuln", 32'(invuln), 0);
    check("async_playing", 32'(playing), 0);
    tick();
    resetn = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
